// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width and byte type used by spi_top and the
// receive-side buffer.
package spi_pkg;
  localparam int SPI_DW = 8;
  typedef logic [SPI_DW-1:0] spi_byte_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// Generic synchronous FIFO: register array, wrapping pointers, occupancy count.
// A write while full is still taken when a read frees a slot in the same cycle.
module spi_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // clr wins over both sides; reads on an empty FIFO are ignored
  assign w_rd    = rd_en & ~w_empty & ~clr;
  assign w_wr    = wr_en & ~clr & (~w_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign count   = r_count;
endmodule

// File: rtl/spi_rx_fifo.sv
// Receive byte buffer behind spi_top: one push per rising edge of spi_done,
// show-ahead valid/ready output, fill level and sticky overflow.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = SPI_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              spi_dout,
  input  logic                       spi_done,
  input  logic                       clr,
  output logic [DW-1:0]              m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Stream handshake: m_data/m_valid are show-ahead; a byte transfers on any
  // rising clk edge where m_valid && m_ready. m_ready is ignored while empty.

  logic          r_done_q;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_full;
  logic [CW-1:0] w_count;

  // done_q is deliberately left alone by clr so a held done cannot re-push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done_q <= 1'b0;
    else      r_done_q <= spi_done;
  end

  assign w_push  = spi_done & ~r_done_q;
  assign w_valid = (w_count != '0);
  assign w_full  = (w_count == FULL_CNT);
  assign w_pop   = w_valid & m_ready;

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (w_push),
    .wr_data (spi_dout),
    .rd_en   (w_pop),
    .rd_data (m_data),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_overflow <= 1'b0;
    else if (clr)                           r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop)    r_overflow <= 1'b1;
  end

  assign m_valid  = w_valid;
  assign level    = w_count;
  assign full     = w_full;
  assign overflow = r_overflow;
endmodule

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

Receive-side byte buffer that sits directly downstream of `spi_top`. It samples the 8-bit received byte on `dout` each time `done` rises and queues it in a small FIFO. It presents the queued bytes to the consuming logic on a valid/ready stream, with fill level and a sticky overflow flag. It decouples the SPI transfer rate from a consumer that may stall.

## Interface
- `DEPTH`, default 8: number of byte entries; power of two, minimum 2.
- `DW`, default 8: data width, taken from `spi_pkg::SPI_DW`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `spi_dout` input DW: received byte from `spi_top.dout`; valid whenever `spi_done` is high.
- `spi_done` input 1: transfer-complete from `spi_top.done`; may be a 1-cycle pulse or held level.
- `clr` input 1: synchronous flush, active-high.
- `m_data` output DW: head-of-queue byte.
- `m_valid` output 1: `m_data` holds a valid byte.
- `m_ready` input 1: consumer accepts `m_data` this cycle.
- `level` output $clog2(DEPTH+1): number of stored bytes, 0..DEPTH.
- `full` output 1: `level == DEPTH`.
- `overflow` output 1: sticky; a byte was dropped.

## Operation
- **Edge detect:** register `done_q <= spi_done`. `push = spi_done & ~done_q`, so a held `done` yields exactly one push. `done_q` resets to 0, so `done` high when reset deasserts counts as one edge.
- **Pop:** `pop = m_valid & m_ready`.
- **Storage:** DEPTH x DW register array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally. `count` is $clog2(DEPTH+1) bits.
- **Push accepted** when not full, or when full and `pop` is active in the same cycle. On accept, `mem[wptr] <= spi_dout` and `wptr` increments.
- **Push while full without pop:** the byte is discarded, `overflow <= 1`, and pointers and count are unchanged.
- **Count update:** +1 on accepted push only, -1 on pop only, unchanged when both or neither occur.
- **Pop on empty:** impossible, since `m_valid` is 0 when empty. `m_ready` is ignored when empty.
- **Show-ahead output:** `m_data = mem[rptr]` (combinational read), `m_valid = (count != 0)`, `level = count`, `full = (count == DEPTH)`.
- **`clr` has priority** over push and pop in the same cycle. It zeroes the pointers, count and `overflow`; any push or pop in that cycle is lost. `clr` does not clear `done_q`.
- **No state machine.** The control is pointer/counter based, with a single overflow flag.

## Timing
- **Reset (rst=0):** asynchronously sets `m_valid=0`, `level=0`, `full=0`, `overflow=0`, `done_q=0`, pointers=0. `m_data` is don't-care while `m_valid=0`; the memory array is not reset.
- **Latency:** a rising `spi_done` is sampled at edge N, and the byte appears on `m_data` with `m_valid=1` after edge N (visible in cycle N+1). Write-to-valid latency is therefore 1 cycle.
- **Pop:** the consumer pops at edge M while `m_valid & m_ready`. The next byte, or `m_valid=0`, appears after edge M.
- **Throughput:** one pop per cycle. Pushes are limited to one per two cycles, because `done` must fall between edges.
- **Overflow:** sets after the edge at which the drop occurs. It stays set until `clr` or reset.
- **Reset mid-stream:** all queued bytes are lost, and there is no partial-state recovery.

## Structure
- **Package `spi_pkg`:** `SPI_DW = 8` and `typedef logic [SPI_DW-1:0] spi_byte_t`. `spi_top` and this block share both.
- **Sub-module `spi_sync_fifo`:** a generic DEPTH/DW synchronous FIFO with `wr_en`, `rd_en`, `clr` and `count`. It contains the array, the pointers, the count and the full-with-pop accept rule.
- **`spi_rx_fifo`** itself adds the edge detector, the valid/ready mapping and the overflow flag.

## Test plan
- **Single byte:** after reset, pulse `spi_done` for 1 cycle with `spi_dout=8'hA5`. Required: `m_valid=1`, `m_data=8'hA5`, `level=1` one cycle later. Then `m_ready=1` for 1 cycle, and `level` returns to 0 with `m_valid=0`.
- **Held done:** hold `spi_done=1` for 10 cycles with `spi_dout=8'h3C`. Required: exactly one push, `level=1`.
- **Fill and overflow:** push `8'h01`..`8'h08` with `m_ready=0`. Required: `full=1`, `overflow=0`. A ninth push of `8'h09` leaves `level=8` and `overflow=1`. Draining then returns 01..08 in order, and `overflow` stays 1.
- **Full with simultaneous push and pop:** with `full=1`, pop in the same cycle as a `done` edge carrying `8'hEE`. Required: `level` stays 8, `overflow=0`, and `8'hEE` emerges last.
- **Wrap-around:** 20 pushes of `8'h10`..`8'h23`, interleaved with pops so that `level` never exceeds 3. Required: output order is exactly 10..23 and there is no overflow.
- **Flush:** with `level=5` and `overflow=1`, assert `clr` in the same cycle as a push and a pop. Required: next cycle `level=0`, `m_valid=0`, `overflow=0`.
- **Async reset mid-stream:** drop `rst` with `level=4`. Required: outputs go to their reset values immediately, without waiting for a clock edge.
